// File: rtl/xalu_ise_dispatch.sv
// xalu_ise_dispatch: issues one decoded custom-opcode instruction to the ISE ALU and returns the
// result or an illegal-instruction flag to writeback. Optional: XALU_ISE_TIMEOUT_EN bounds the ISE wait.

module xalu_ise_dispatch #(
    parameter int TIMEOUT = 8
) (
    input  logic        ise_clk,
    input  logic        ise_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,
    input  logic        flush,
    output logic [5:0]  ise_fn,
    output logic [6:0]  ise_imm,
    output logic [31:0] ise_in1,
    output logic [31:0] ise_in2,
    output logic        ise_val,
    input  logic        ise_oval,
    input  logic [31:0] ise_out,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [4:0]  resp_rd_idx,
    output logic [31:0] resp_data,
    output logic        resp_illegal,
    output logic [1:0]  dbg_state_o
);

    // Handshakes: req and resp transfer in a cycle where valid and ready are both high.
    // resp_valid holds with its payload until that transfer; only flush or reset drop it early.

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [5:0]  fn_q, fn_d;
    logic [6:0]  imm_q, imm_d;
    logic [31:0] in1_q, in1_d;
    logic [31:0] in2_q, in2_d;
    logic [4:0]  rd_q, rd_d;
    logic [31:0] data_q, data_d;
    logic        ill_q, ill_d;

    logic        is_custom;
    logic [1:0]  cust_idx;
    logic        accept;
    logic        timeout_hit;

    // The rs1/rs2 index fields are resolved by the core; only the operand values arrive here.
    logic unused_insn_bits;
    assign unused_insn_bits = ^req_insn[24:15];

    always_comb begin
        is_custom = 1'b1;
        cust_idx  = 2'd0;
        case (req_insn[6:0])
            7'b0001011: cust_idx = 2'd0;
            7'b0101011: cust_idx = 2'd1;
            7'b1011011: cust_idx = 2'd2;
            7'b1111011: cust_idx = 2'd3;
            default:    is_custom = 1'b0;
        endcase
    end

    assign req_ready = (state_q == ST_IDLE) & ~flush;
    assign accept    = req_valid & req_ready;

`ifdef XALU_ISE_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    logic [7:0] cnt_q, cnt_d;

    // Saturating wait counter: cleared on accept, counts EXEC cycles without a result.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && is_custom) begin
            cnt_d = 8'd0;
        end else if (state_q == ST_EXEC && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout_hit = (cnt_q == TO_LAST);
`else
    logic [7:0] unused_timeout;
    assign unused_timeout = 8'(TIMEOUT);
    assign timeout_hit    = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        fn_d    = fn_q;
        imm_d   = imm_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        rd_d    = rd_q;
        data_d  = data_q;
        ill_d   = ill_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        rd_d = req_insn[11:7];
                        if (is_custom) begin
                            fn_d    = {1'b0, req_insn[14:12], cust_idx};
                            imm_d   = req_insn[31:25];
                            in1_d   = req_rs1;
                            in2_d   = req_rs2;
                            state_d = ST_EXEC;
                        end else begin
                            ill_d   = 1'b1;
                            data_d  = 32'd0;
                            state_d = ST_RESP;
                        end
                    end
                end
                ST_EXEC: begin
                    // A result arriving on the last allowed cycle beats the timeout.
                    if (ise_oval) begin
                        data_d  = ise_out;
                        ill_d   = 1'b0;
                        state_d = ST_RESP;
                    end else if (timeout_hit) begin
                        data_d  = 32'd0;
                        ill_d   = 1'b1;
                        state_d = ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (resp_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst) begin
            state_q <= ST_IDLE;
            fn_q    <= 6'd0;
            imm_q   <= 7'd0;
            in1_q   <= 32'd0;
            in2_q   <= 32'd0;
            rd_q    <= 5'd0;
            data_q  <= 32'd0;
            ill_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            fn_q    <= fn_d;
            imm_q   <= imm_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            ill_q   <= ill_d;
        end
    end

    assign ise_fn       = fn_q;
    assign ise_imm      = imm_q;
    assign ise_in1      = in1_q;
    assign ise_in2      = in2_q;
    assign ise_val      = (state_q == ST_EXEC);
    assign resp_valid   = (state_q == ST_RESP);
    assign resp_rd_idx  = rd_q;
    assign resp_data    = data_q;
    assign resp_illegal = ill_q;
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_xalu_ise_dispatch.sv
// Bench for xalu_ise_dispatch: vector table, random transactions against a reference model,
// and hand-written flush / backpressure / timeout / reset sequences.

module tb_xalu_ise_dispatch;

    localparam int TIMEOUT = 8;

    logic        ise_clk = 1'b0;
    logic        ise_rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_insn = 32'd0;
    logic [31:0] req_rs1 = 32'd0;
    logic [31:0] req_rs2 = 32'd0;
    logic        flush = 1'b0;
    logic [5:0]  ise_fn;
    logic [6:0]  ise_imm;
    logic [31:0] ise_in1;
    logic [31:0] ise_in2;
    logic        ise_val;
    logic        ise_oval;
    logic [31:0] ise_out;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [4:0]  resp_rd_idx;
    logic [31:0] resp_data;
    logic        resp_illegal;
    logic [1:0]  dbg_state;

    int          ise_lat = 0;
    logic        ise_mute = 1'b0;
    int          val_cnt;
    int          cyc_cnt = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] exp_q[$];

    xalu_ise_dispatch #(.TIMEOUT(TIMEOUT)) dut (
        .ise_clk(ise_clk), .ise_rst(ise_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_insn(req_insn),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .flush(flush),
        .ise_fn(ise_fn), .ise_imm(ise_imm), .ise_in1(ise_in1), .ise_in2(ise_in2),
        .ise_val(ise_val), .ise_oval(ise_oval), .ise_out(ise_out),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rd_idx(resp_rd_idx),
        .resp_data(resp_data), .resp_illegal(resp_illegal), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset / ISE model ----------------
    always #5 ise_clk = ~ise_clk;
    always @(posedge ise_clk) cyc_cnt <= cyc_cnt + 1;

    always @(posedge ise_clk or posedge ise_rst) begin
        if (ise_rst)       val_cnt <= 0;
        else if (!ise_val) val_cnt <= 0;
        else if (val_cnt < 1000) val_cnt <= val_cnt + 1;
    end
    assign ise_out  = ise_in1 ^ ise_in2;
    assign ise_oval = ise_val & ~ise_mute & (val_cnt >= ise_lat);

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1, "watchdog");
    end

    // ---------------- helpers / driver tasks ----------------
    task automatic tick();
        @(posedge ise_clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mk_insn(input logic [6:0] f7, input logic [2:0] f3,
                                            input logic [4:0] rd, input logic [6:0] op);
        return {f7, 5'd0, 5'd0, f3, rd, op};
    endfunction

    // Reference: {is_custom, custom index} straight from the opcode table.
    function automatic logic [2:0] model_decode(input logic [6:0] op);
        case (op)
            7'b0001011: return 3'b100;
            7'b0101011: return 3'b101;
            7'b1011011: return 3'b110;
            7'b1111011: return 3'b111;
            default:    return 3'b000;
        endcase
    endfunction

    task automatic run_txn(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                           input int lat, output logic [31:0] r_data, output logic r_ill,
                           output logic [4:0] r_rd, output logic [5:0] r_fn, output logic [6:0] r_imm,
                           output int r_cyc, output int r_vcyc);
        ise_lat    = lat;
        req_insn   = insn;
        req_rs1    = rs1;
        req_rs2    = rs2;
        req_valid  = 1'b1;
        resp_ready = 1'b1;
        r_vcyc = 0;
        r_fn   = 6'd0;
        r_imm  = 7'd0;
        tick();
        req_valid = 1'b0;
        r_cyc = 1;
        while (!resp_valid && r_cyc < 200) begin
            if (ise_val) begin
                r_vcyc++;
                r_fn  = ise_fn;
                r_imm = ise_imm;
            end
            tick();
            r_cyc++;
        end
        if (!resp_valid) chk("txn_resp_timeout", 32'(resp_valid), 32'd1);
        r_data = resp_data;
        r_ill  = resp_illegal;
        r_rd   = resp_rd_idx;
        tick();
    endtask

    typedef struct {
        logic [31:0] insn;
        logic [31:0] rs1;
        logic [31:0] rs2;
        int          lat;
        logic [31:0] exp_data;
        logic        exp_ill;
        logic [4:0]  exp_rd;
        logic [5:0]  exp_fn;
        logic [6:0]  exp_imm;
        int          exp_cyc;
    } vec_t;

    vec_t        vecs[6];
    logic [6:0]  cust_ops[4];

    initial begin
        logic [31:0] r_data, e_data, insn, rs1, rs2;
        logic        r_ill, m_ill;
        logic [4:0]  r_rd;
        logic [5:0]  r_fn, m_fn;
        logic [6:0]  r_imm;
        logic [2:0]  dec;
        int          r_cyc, r_vcyc, m_cyc, lat, k, vc, t0;

        vecs[0] = '{mk_insn(7'h20, 3'd0,   5'd5,  7'b0101011), 32'h0000FFFF, 32'h12340000, 0,
                    32'h1234FFFF, 1'b0, 5'd5,  6'h01, 7'h20, 2};
        vecs[1] = '{mk_insn(7'h00, 3'd0,   5'd3,  7'b0110011), 32'hAAAA5555, 32'h00000001, 0,
                    32'h00000000, 1'b1, 5'd3,  6'h00, 7'h00, 1};
        vecs[2] = '{mk_insn(7'h7F, 3'b101, 5'd31, 7'b0001011), 32'hFFFFFFFF, 32'h0F0F0F0F, 2,
                    32'hF0F0F0F0, 1'b0, 5'd31, 6'h14, 7'h7F, 4};
        vecs[3] = '{mk_insn(7'h00, 3'b010, 5'd0,  7'b1011011), 32'h12345678, 32'h12345678, 1,
                    32'h00000000, 1'b0, 5'd0,  6'h0A, 7'h00, 3};
        vecs[4] = '{mk_insn(7'h55, 3'b111, 5'd17, 7'b1111011), 32'hDEADBEEF, 32'h00000000, 3,
                    32'hDEADBEEF, 1'b0, 5'd17, 6'h1F, 7'h55, 5};
        vecs[5] = '{mk_insn(7'h7F, 3'b111, 5'd9,  7'b0001010), 32'h00000001, 32'h00000002, 0,
                    32'h00000000, 1'b1, 5'd9,  6'h00, 7'h00, 1};
        cust_ops[0] = 7'b0001011;
        cust_ops[1] = 7'b0101011;
        cust_ops[2] = 7'b1011011;
        cust_ops[3] = 7'b1111011;

        // ---------------- reset state ----------------
        repeat (2) @(posedge ise_clk);
        #1;
        ise_rst = 1'b0;
        #1;
        chk("rst_req_ready",  32'(req_ready),   32'd1);
        chk("rst_ise_val",    32'(ise_val),     32'd0);
        chk("rst_ise_fn",     32'(ise_fn),      32'd0);
        chk("rst_ise_imm",    32'(ise_imm),     32'd0);
        chk("rst_ise_in1",    ise_in1,          32'd0);
        chk("rst_ise_in2",    ise_in2,          32'd0);
        chk("rst_resp_valid", 32'(resp_valid),  32'd0);
        chk("rst_resp_data",  resp_data,        32'd0);
        chk("rst_resp_ill",   32'(resp_illegal),32'd0);
        chk("rst_resp_rd",    32'(resp_rd_idx), 32'd0);
        tick();

        // ---------------- vector table ----------------
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(vecs[i].exp_data);
            run_txn(vecs[i].insn, vecs[i].rs1, vecs[i].rs2, vecs[i].lat,
                    r_data, r_ill, r_rd, r_fn, r_imm, r_cyc, r_vcyc);
            e_data = exp_q.pop_front();
            chk("tbl_data",    r_data,        e_data);
            chk("tbl_illegal", 32'(r_ill),    32'(vecs[i].exp_ill));
            chk("tbl_rd",      32'(r_rd),     32'(vecs[i].exp_rd));
            chk("tbl_latency", 32'(r_cyc),    32'(vecs[i].exp_cyc));
            chk("tbl_val_cyc", 32'(r_vcyc),   vecs[i].exp_ill ? 32'd0 : 32'(vecs[i].exp_cyc - 1));
            if (!vecs[i].exp_ill) begin
                chk("tbl_fn",  32'(r_fn),  32'(vecs[i].exp_fn));
                chk("tbl_imm", 32'(r_imm), 32'(vecs[i].exp_imm));
            end
            chk("tbl_req_ready_after", 32'(req_ready), 32'd1);
        end

        // ---------------- back-to-back throughput ----------------
        t0 = cyc_cnt;
        for (int i = 0; i < 3; i++) begin
            run_txn(vecs[0].insn, 32'(i), 32'h5A5A0000, 0, r_data, r_ill, r_rd, r_fn, r_imm, r_cyc, r_vcyc);
            chk("b2b_data", r_data, 32'(i) ^ 32'h5A5A0000);
        end
        chk("b2b_cycles", 32'(cyc_cnt - t0), 32'd9);

        // ---------------- randomized vs reference model ----------------
        for (int n = 0; n < 40; n++) begin
            insn = $urandom;
            if ($urandom_range(0, 3) != 0) insn[6:0] = cust_ops[$urandom_range(0, 3)];
            rs1 = $urandom;
            rs2 = $urandom;
            lat = $urandom_range(0, 6);
            dec   = model_decode(insn[6:0]);
            m_ill = ~dec[2];
            m_fn  = {1'b0, insn[14:12], dec[1:0]};
            m_cyc = m_ill ? 1 : 2 + lat;
            exp_q.push_back(m_ill ? 32'd0 : (rs1 ^ rs2));
            run_txn(insn, rs1, rs2, lat, r_data, r_ill, r_rd, r_fn, r_imm, r_cyc, r_vcyc);
            e_data = exp_q.pop_front();
            chk("rnd_data",    r_data,       e_data);
            chk("rnd_illegal", 32'(r_ill),   32'(m_ill));
            chk("rnd_rd",      32'(r_rd),    32'(insn[11:7]));
            chk("rnd_latency", 32'(r_cyc),   32'(m_cyc));
            if (!m_ill) begin
                chk("rnd_fn",  32'(r_fn),  32'(m_fn));
                chk("rnd_imm", 32'(r_imm), 32'(insn[31:25]));
            end
        end

        // ---------------- backpressure ----------------
        resp_ready = 1'b0;
        ise_lat    = 0;
        req_insn   = mk_insn(7'h01, 3'b011, 5'd12, 7'b1111011);
        req_rs1    = 32'hCAFE0000;
        req_rs2    = 32'h0000BABE;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int c = 2; c <= 5; c++) begin
            chk("bp_valid",     32'(resp_valid),   32'd1);
            chk("bp_data",      resp_data,         32'hCAFEBABE);
            chk("bp_rd",        32'(resp_rd_idx),  32'd12);
            chk("bp_illegal",   32'(resp_illegal), 32'd0);
            chk("bp_req_ready", 32'(req_ready),    32'd0);
            tick();
        end
        resp_ready = 1'b1;
        chk("bp_valid_hs",  32'(resp_valid), 32'd1);
        chk("bp_data_hs",   resp_data,       32'hCAFEBABE);
        tick();
        chk("bp_valid_done",     32'(resp_valid), 32'd0);
        chk("bp_req_ready_done", 32'(req_ready),  32'd1);

        // ---------------- ISE never answers ----------------
        ise_mute  = 1'b1;
        req_insn  = vecs[0].insn;
        req_rs1   = 32'h1;
        req_rs2   = 32'h2;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        k  = 1;
        vc = 0;
        while (!resp_valid && k < 100) begin
            if (ise_val) vc++;
            tick();
            k++;
        end
`ifdef XALU_ISE_TIMEOUT_EN
        chk("to_resp_valid", 32'(resp_valid),   32'd1);
        chk("to_val_cycles", 32'(vc),           32'(TIMEOUT));
        chk("to_illegal",    32'(resp_illegal), 32'd1);
        chk("to_data",       resp_data,         32'd0);
        tick();
        chk("to_done_valid", 32'(resp_valid),   32'd0);
`else
        chk("noto_resp_valid", 32'(resp_valid), 32'd0);
        chk("noto_ise_val",    32'(ise_val),    32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("noto_flush_idle",  32'(req_ready), 32'd1);
        chk("noto_flush_val",   32'(ise_val),   32'd0);
        chk("noto_flush_resp",  32'(resp_valid),32'd0);
`endif
        ise_mute = 1'b0;
        tick();

        // ---------------- flush vs ise_oval in the same cycle ----------------
        flush = 1'b1;
        #1;
        chk("fl_idle_req_ready", 32'(req_ready), 32'd0);
        flush = 1'b0;
        #1;
        chk("fl_idle_req_ready_rel", 32'(req_ready), 32'd1);
        tick();
        req_insn  = vecs[2].insn;
        req_rs1   = 32'h00FF00FF;
        req_rs2   = 32'h0F0F0F0F;
        ise_lat   = 1;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("fl_oval_present", 32'(ise_oval), 32'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        #1;
        chk("fl_resp_valid", 32'(resp_valid), 32'd0);
        chk("fl_ise_val",    32'(ise_val),    32'd0);
        chk("fl_req_ready",  32'(req_ready),  32'd1);
        chk("fl_state_idle", 32'(dbg_state),  32'd0);
        tick();
        chk("fl_resp_valid_later", 32'(resp_valid), 32'd0);

        // ---------------- reset while in RESP ----------------
        resp_ready = 1'b0;
        ise_lat    = 0;
        req_insn   = mk_insn(7'h33, 3'b110, 5'd7, 7'b0101011);
        req_rs1    = 32'h11111111;
        req_rs2    = 32'h22222222;
        req_valid  = 1'b1;
        tick();
        req_valid = 1'b0;
        tick();
        chk("rr_pre_valid", 32'(resp_valid), 32'd1);
        chk("rr_pre_data",  resp_data,       32'h33333333);
        #2;
        ise_rst = 1'b1;
        #1;
        chk("rr_resp_valid", 32'(resp_valid),   32'd0);
        chk("rr_resp_data",  resp_data,         32'd0);
        chk("rr_resp_ill",   32'(resp_illegal), 32'd0);
        chk("rr_resp_rd",    32'(resp_rd_idx),  32'd0);
        chk("rr_ise_fn",     32'(ise_fn),       32'd0);
        chk("rr_ise_imm",    32'(ise_imm),      32'd0);
        chk("rr_ise_in1",    ise_in1,           32'd0);
        chk("rr_ise_in2",    ise_in2,           32'd0);
        chk("rr_ise_val",    32'(ise_val),      32'd0);
        chk("rr_req_ready",  32'(req_ready),    32'd1);
        ise_rst = 1'b0;
        tick();
        run_txn(vecs[4].insn, vecs[4].rs1, vecs[4].rs2, 1, r_data, r_ill, r_rd, r_fn, r_imm, r_cyc, r_vcyc);
        chk("rr_after_data",    r_data,      32'hDEADBEEF);
        chk("rr_after_rd",      32'(r_rd),   32'd17);
        chk("rr_after_latency", 32'(r_cyc),  32'd3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
